spi_bus_arbiter: RTL
====================

Name: spi_bus_arbiter

Overview:
- Shares one SPI master core between NUM_REQ requesters, which may be separate drivers or register blocks.
- Grants the core round-robin and streams a multi-word transaction of req_len words for the granted requester: loads each word, pulses start, tracks busy, and returns each received word.
- Sits between the requesters and the SPI core's parallel side (data out, start, busy, data in).
- Adds a start-acknowledge timeout so a hung core cannot lock the bus.

Parameters:
- NUM_REQ, 2: number of requesters; valid range 2..8.
- BUS_WIDTH, 8: SPI word width; must equal the core's word width.
- LEN_WIDTH, 4: width of each requester's word-count field.
- TO_CYCLES, 16: cycles allowed for core_busy to rise after core_start is asserted.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  per-requester transaction request, level-sensitive.
- req_len  in  NUM_REQ*LEN_WIDTH  word count, one field per requester; requester i uses bits [i*LEN_WIDTH +: LEN_WIDTH].
- tx_data  in  NUM_REQ*BUS_WIDTH  next word to send, one field per requester.
- tx_ack  out  NUM_REQ  one-cycle, one-hot pulse: the granted requester's tx_data has been consumed and it must present the next word.
- grant  out  NUM_REQ  one-hot owner of the core; all zero when idle.
- rx_data  out  BUS_WIDTH  last received word.
- rx_valid  out  NUM_REQ  one-cycle, one-hot pulse: rx_data is valid for that requester.
- done  out  NUM_REQ  one-cycle, one-hot pulse at transaction end (normal completion or abort).
- err  out  1  one-cycle pulse, coincident with done, when a transaction is aborted by timeout.
- core_dout  out  BUS_WIDTH  word to the core; held stable while core_start is high.
- core_start  out  1  start request to the core.
- core_busy  in  1  core transfer in progress.
- core_din  in  BUS_WIDTH  word received by the core.

Behaviour:
- Reset values: grant=0, tx_ack=0, rx_valid=0, done=0, err=0, rx_data=0, core_dout=0, core_start=0.
- Internal reset values: state=IDLE, last_grant=NUM_REQ-1 (so requester 0 has first priority), remaining=0, timer=0.
- Reset asserted mid-transaction aborts immediately with no done pulse; core_start is low from reset assertion onward.
- IDLE:
  - If req has no bits set, stay in IDLE.
  - Otherwise pick the first set req bit searching upward from last_grant+1, wrapping modulo NUM_REQ.
  - Set grant, latch remaining=req_len[g], go to LOAD.
  - If the latched length is 0: pulse done[g] in the next cycle with no core activity, return to IDLE, and update last_grant.
- LOAD (1 cycle): core_dout<=tx_data[g], pulse tx_ack[g], core_start<=1, timer<=0, go to WAIT_BUSY.
- WAIT_BUSY:
  - Hold core_start high and core_dout stable; timer increments every cycle.
  - core_busy=1: core_start<=0, go to WAIT_DONE.
  - timer==TO_CYCLES-1 with core_busy still 0: core_start<=0, pulse done[g] and err, grant<=0, last_grant<=g, go to IDLE.
- WAIT_DONE: wait for core_busy=0, then go to CAPTURE. No timeout applies in this state.
- CAPTURE (1 cycle):
  - rx_data<=core_din, pulse rx_valid[g], remaining<=remaining-1.
  - If remaining was 1: pulse done[g], grant<=0, last_grant<=g, go to IDLE. Otherwise go to LOAD.
- Minimum per-word overhead beyond the core's own busy time: LOAD + CAPTURE + 1 cycle of WAIT_BUSY = 3 cycles.
- Requests are not preemptive:
  - Deasserting req[g] mid-transaction is ignored; the transaction runs to completion.
  - req_len and req changes from other requesters are ignored until IDLE.
- A requester holding req high after its done pulse is re-arbitrated normally. Round-robin guarantees that any other pending requester is served first.
- Simultaneous events: done and a new request in the same cycle are handled by evaluating the new request in IDLE on the following cycle. There is no back-to-back grant in the done cycle.
- tx_ack, rx_valid and done are never asserted for a non-granted requester; at most one bit of each is set in any cycle.
- remaining uses LEN_WIDTH bits; the maximum transaction length is 2**LEN_WIDTH-1 words.

Test Plan:
- Single transaction: req=01, req_len[0]=3, tx_data[0] = A5, 3C, F0 on successive tx_ack pulses; core model echoes inverted data. Required: 3 tx_ack[0] pulses, rx_data = 5A, C3, 0F with rx_valid[0], then exactly one done[0], err=0, grant back to 0.
- Round-robin fairness: req=11 held continuously, both lengths 1. Required grant sequence 01, 10, 01, 10 for four transactions; requester 0 first after reset.
- Zero-length request: req=10, req_len[1]=0. Required: done[1] pulse within 3 cycles, core_start never asserted, no tx_ack or rx_valid.
- Timeout: core model never raises busy, req=01, len=2. Required: core_start high for exactly TO_CYCLES=16 cycles, then done[0] and err together, grant=0, no rx_valid.
- Reset mid-transfer: assert rst_n=0 during WAIT_DONE of word 2 of 4. Required: all outputs at reset values immediately, no done pulse. After release, a new req=01 is granted to requester 0.
- Requester drop: deassert req[0] after the first tx_ack of a len=3 transaction. Required: all 3 words still transferred and done[0] pulses.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI master core between NUM_REQ requesters,
// streaming a multi-word transaction per grant with a start-acknowledge timeout.
module spi_bus_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int BUS_WIDTH = 8,
  parameter int LEN_WIDTH = 4,
  parameter int TO_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]   req_len,
  input  logic [NUM_REQ*BUS_WIDTH-1:0]   tx_data,
  output logic [NUM_REQ-1:0]             tx_ack,
  output logic [NUM_REQ-1:0]             grant,
  output logic [BUS_WIDTH-1:0]           rx_data,
  output logic [NUM_REQ-1:0]             rx_valid,
  output logic [NUM_REQ-1:0]             done,
  output logic                           err,
  output logic [BUS_WIDTH-1:0]           core_dout,
  output logic                           core_start,
  input  logic                           core_busy,
  input  logic [BUS_WIDTH-1:0]           core_din
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int TMR_W = $clog2(TO_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TO_CYCLES - 1);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    CAPTURE
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     last_grant;
  logic [IDX_W-1:0]     g_idx;
  logic [LEN_WIDTH-1:0] remaining;
  logic [TMR_W-1:0]     timer;

  logic                 pick_valid;
  logic [IDX_W-1:0]     pick_idx;
  logic [LEN_WIDTH-1:0] pick_len;
  logic [BUS_WIDTH-1:0] cur_tx;
  logic [NUM_REQ-1:0]   cur_onehot;

  // Search upward from last_grant+1; the smallest rotation offset is assigned last and wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (i == (int'(last_grant) + k) % NUM_REQ && req[i]) begin
          pick_valid = 1'b1;
          pick_idx   = IDX_W'(i);
        end
      end
    end
  end

  always_comb begin
    pick_len   = '0;
    cur_tx     = '0;
    cur_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == pick_idx) pick_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      if (IDX_W'(i) == g_idx) begin
        cur_tx        = tx_data[i*BUS_WIDTH +: BUS_WIDTH];
        cur_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      g_idx      <= '0;
      remaining  <= '0;
      timer      <= '0;
      grant      <= '0;
      tx_ack     <= '0;
      rx_valid   <= '0;
      done       <= '0;
      err        <= 1'b0;
      rx_data    <= '0;
      core_dout  <= '0;
      core_start <= 1'b0;
    end else begin
      tx_ack   <= '0;
      rx_valid <= '0;
      done     <= '0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_valid) begin
            g_idx     <= pick_idx;
            grant     <= '0;
            grant[pick_idx] <= 1'b1;
            remaining <= pick_len;
            state     <= LOAD;
          end
        end
        LOAD: begin
          // A zero-length request completes without ever touching the core.
          if (remaining == '0) begin
            done       <= cur_onehot;
            grant      <= '0;
            last_grant <= g_idx;
            state      <= IDLE;
          end else begin
            core_dout  <= cur_tx;
            tx_ack     <= cur_onehot;
            core_start <= 1'b1;
            timer      <= '0;
            state      <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (core_busy) begin
            core_start <= 1'b0;
            state      <= WAIT_DONE;
          end else if (timer == TMR_LAST) begin
            core_start <= 1'b0;
            done       <= cur_onehot;
            err        <= 1'b1;
            grant      <= '0;
            last_grant <= g_idx;
            state      <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!core_busy) state <= CAPTURE;
        end
        CAPTURE: begin
          rx_data   <= core_din;
          rx_valid  <= cur_onehot;
          remaining <= remaining - 1'b1;
          if (remaining == LEN_ONE) begin
            done       <= cur_onehot;
            grant      <= '0;
            last_grant <= g_idx;
            state      <= IDLE;
          end else begin
            state <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
